// File: rtl/adaptive_tl_sequencer_if.sv
// Sensor-side and lamp-side signal bundle of the adaptive traffic-light sequencer.
// The sensor conditioning logic drives through master; the sequencer sits on slave.
interface adaptive_tl_sequencer_if #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
);
  logic                 tick;
  logic [NUM_LANES-1:0] demand;
  logic [NUM_LANES-1:0] congest;
  logic                 emg_req;
  logic [LANE_W-1:0]    emg_lane;
  logic [NUM_LANES-1:0] green;
  logic [NUM_LANES-1:0] yellow;
  logic [LANE_W-1:0]    active_lane;
  logic [2:0]           phase;
  logic                 served;

  modport master (
    output tick, demand, congest, emg_req, emg_lane,
    input  green, yellow, active_lane, phase, served
  );
  modport slave (
    input  tick, demand, congest, emg_req, emg_lane,
    output green, yellow, active_lane, phase, served
  );
endinterface

// File: rtl/adaptive_tl_sequencer.sv
// N-lane round-robin traffic-light sequencer with tick-timed phases,
// a single congestion extension per green and emergency pre-emption.
module tl_lamp_slice #(
  parameter int LANE_W = 2,
  parameter int IDX    = 0
) (
  input  logic [LANE_W-1:0] active_lane,
  input  logic              grn_en,
  input  logic              yel_en,
  output logic              g,
  output logic              y
);
  logic hit;
  assign hit = (active_lane == LANE_W'(IDX));
  assign g   = grn_en && hit;
  assign y   = yel_en && hit;
endmodule

module adaptive_tl_sequencer #(
  parameter int NUM_LANES = 4,
  parameter int CNT_W     = 8,
  parameter int GREEN_MIN = 8,
  parameter int GREEN_EXT = 8,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  adaptive_tl_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    SCAN = 3'd0, GREEN = 3'd1, EXT = 3'd2, YELLOW = 3'd3, ALLRED = 3'd4
  } phase_e;

  phase_e            st, st_n;
  logic [LANE_W-1:0] ptr, ptr_n, al, al_n, rr_lane;
  logic [CNT_W-1:0]  timer, tmr_n;
  logic              ext_used, ext_n;
  logic              emg_vld, rr_hit, expire, grn_en, yel_en;

  // Out-of-range emergency lanes (non power-of-two lane counts) are ignored.
  assign emg_vld = bus.emg_req && (int'(bus.emg_lane) < NUM_LANES);
  assign expire  = bus.tick && (timer == CNT_W'(1));

  // Walk offsets high to low so the nearest demanding lane from ptr wins.
  always_comb begin
    int k;
    rr_hit  = 1'b0;
    rr_lane = ptr;
    k       = 0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= NUM_LANES) k = k - NUM_LANES;
      if (bus.demand[LANE_W'(k)]) begin
        rr_hit  = 1'b1;
        rr_lane = LANE_W'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= SCAN;
      ptr      <= '0;
      al       <= '0;
      timer    <= '0;
      ext_used <= 1'b0;
    end else begin
      st       <= st_n;
      ptr      <= ptr_n;
      al       <= al_n;
      timer    <= tmr_n;
      ext_used <= ext_n;
    end
  end

  always_comb begin
    st_n  = st;
    ptr_n = ptr;
    al_n  = al;
    tmr_n = timer;
    ext_n = ext_used;
    case (st)
      SCAN: begin
        if (emg_vld || rr_hit) begin
          al_n  = emg_vld ? bus.emg_lane : rr_lane;
          tmr_n = CNT_W'(GREEN_MIN);
          ext_n = 1'b0;
          st_n  = GREEN;
        end
      end
      GREEN, EXT: begin
        // Pre-emption for another lane beats expiry; for this lane it freezes the timer.
        if (emg_vld && (bus.emg_lane != al)) begin
          st_n  = YELLOW;
          tmr_n = CNT_W'(YELLOW_T);
        end else if (!emg_vld && bus.tick) begin
          if (expire) begin
            if ((st == GREEN) && bus.congest[al] && !ext_used) begin
              st_n  = EXT;
              tmr_n = CNT_W'(GREEN_EXT);
              ext_n = 1'b1;
            end else begin
              st_n  = YELLOW;
              tmr_n = CNT_W'(YELLOW_T);
            end
          end else begin
            tmr_n = timer - CNT_W'(1);
          end
        end
      end
      YELLOW: begin
        if (expire) begin
          st_n  = ALLRED;
          tmr_n = CNT_W'(ALLRED_T);
        end else if (bus.tick) begin
          tmr_n = timer - CNT_W'(1);
        end
      end
      ALLRED: begin
        if (expire) begin
          st_n  = SCAN;
          ptr_n = (int'(al) == NUM_LANES - 1) ? '0 : al + LANE_W'(1);
        end else if (bus.tick) begin
          tmr_n = timer - CNT_W'(1);
        end
      end
      default: st_n = SCAN;
    endcase
  end

  always_comb begin
    grn_en          = (st == GREEN) || (st == EXT);
    yel_en          = (st == YELLOW);
    bus.served      = (st == ALLRED) && expire;
    bus.phase       = st;
    bus.active_lane = al;
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lamp
    tl_lamp_slice #(.LANE_W(LANE_W), .IDX(l)) u_lamp (
      .active_lane (al),
      .grn_en      (grn_en),
      .yel_en      (yel_en),
      .g           (bus.green[l]),
      .y           (bus.yellow[l])
    );
  end
endmodule

// File: tb/tb_adaptive_tl_sequencer.sv
// Directed scenarios plus randomized traffic for adaptive_tl_sequencer,
// checked cycle by cycle against a behavioural lane-service model.
module tb_adaptive_tl_sequencer;
  localparam int N = 4, LW = 2, GMIN = 4, GEXT = 3, YT = 2, ART = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adaptive_tl_sequencer_if #(.NUM_LANES(N)) tif ();

  adaptive_tl_sequencer #(
    .NUM_LANES(N), .CNT_W(8), .GREEN_MIN(GMIN), .GREEN_EXT(GEXT),
    .YELLOW_T(YT), .ALLRED_T(ART)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tif.slave)
  );

  int tests = 0, fails = 0;
  string cur = "init";

  // model: phase code, lane in service, round-robin start, ticks left, extension used
  int m_ph, m_lane, m_ptr, m_rem;
  bit m_ext;

  logic [N-1:0]  last_g, last_y;
  logic          last_srv;
  logic [LW-1:0] last_al;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dut_pack();
    return {18'b0, tif.green, tif.yellow, tif.phase, tif.active_lane, tif.served};
  endfunction

  function automatic logic [31:0] m_out();
    logic [N-1:0] g, y;
    logic srv;
    g = '0;
    y = '0;
    if (m_ph == 1 || m_ph == 2) g[m_lane] = 1'b1;
    if (m_ph == 3) y[m_lane] = 1'b1;
    srv = (m_ph == 4) && tif.tick && (m_rem == 1);
    return {18'b0, g, y, 3'(m_ph), 2'(m_lane), srv};
  endfunction

  task automatic m_reset();
    m_ph = 0; m_lane = 0; m_ptr = 0; m_rem = 0; m_ext = 0;
  endtask

  task automatic m_step();
    bit ev;
    int el;
    ev = tif.emg_req && (int'(tif.emg_lane) < N);
    el = int'(tif.emg_lane);
    case (m_ph)
      0: begin
        int sel;
        sel = -1;
        if (ev) sel = el;
        else
          for (int i = 0; i < N; i++)
            if (sel < 0 && tif.demand[(m_ptr + i) % N]) sel = (m_ptr + i) % N;
        if (sel >= 0) begin
          m_lane = sel; m_rem = GMIN; m_ext = 0; m_ph = 1;
        end
      end
      1, 2: begin
        if (ev && el != m_lane) begin
          m_ph = 3; m_rem = YT;
        end else if (!ev && tif.tick) begin
          if (m_rem > 1) m_rem--;
          else if (m_ph == 1 && tif.congest[m_lane] && !m_ext) begin
            m_ph = 2; m_rem = GEXT; m_ext = 1;
          end else begin
            m_ph = 3; m_rem = YT;
          end
        end
      end
      3: if (tif.tick) begin
        if (m_rem > 1) m_rem--;
        else begin m_ph = 4; m_rem = ART; end
      end
      default: if (tif.tick) begin
        if (m_rem > 1) m_rem--;
        else begin m_ph = 0; m_ptr = (m_lane + 1) % N; end
      end
    endcase
  endtask

  // Inputs are set at posedge+1; outputs checked and model advanced at negedge.
  task automatic step_cyc();
    @(negedge clk);
    chk(cur, dut_pack(), m_out());
    last_g   = tif.green;
    last_y   = tif.yellow;
    last_srv = tif.served;
    last_al  = tif.active_lane;
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tif.demand = '0; tif.congest = '0; tif.emg_req = 1'b0; tif.emg_lane = '0; tif.tick = 1'b1;
    rst_n = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int ng, ny, ns, seq;
    logic [N-1:0] lit;
    bit emg_on;
    tif.tick = 1'b0; tif.demand = '0; tif.congest = '0;
    tif.emg_req = 1'b0; tif.emg_lane = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", dut_pack(), 32'h0);
    rst_n = 1'b1;
    tif.tick = 1'b1;

    // single demanding lane, served twice with wrap
    cur = "s1_wrap"; tif.demand = 4'b0001;
    ng = 0; ny = 0; ns = 0;
    repeat (16) begin
      step_cyc();
      ng += int'(last_g == 4'b0001); ny += int'(last_y == 4'b0001); ns += int'(last_srv);
    end
    chk("s1_green_cycles", ng, 8);
    chk("s1_yellow_cycles", ny, 4);
    chk("s1_served_pulses", ns, 2);

    // skip lanes without demand
    do_reset(); cur = "s2_skip"; tif.demand = 4'b1010;
    seq = 0; ns = 0; lit = '0;
    repeat (24) begin
      step_cyc();
      lit |= last_g | last_y;
      if (last_srv) begin seq = (seq << 2) | int'(last_al); ns++; end
    end
    chk("s2_service_count", ns, 3);
    chk("s2_service_order", seq, 29);
    chk("s2_idle_lanes_dark", {28'b0, lit & 4'b0101}, 0);

    // single extension with congestion held
    do_reset(); cur = "s3_ext"; tif.demand = 4'b0100; tif.congest = 4'b0100;
    ng = 0; ny = 0;
    repeat (11) begin
      step_cyc();
      ng += int'(last_g == 4'b0100); ny += int'(last_y == 4'b0100);
    end
    chk("s3_green_cycles", ng, 7);
    chk("s3_yellow_cycles", ny, 2);
    tif.demand = '0; tif.congest = '0;

    // pre-emption of lane 0 by emergency on lane 3
    do_reset(); cur = "s4_preempt"; tif.demand = 4'b0001;
    step_cyc(); step_cyc();
    tif.emg_req = 1'b1; tif.emg_lane = 2'd3; tif.demand = '0;
    step_cyc(); step_cyc();
    chk("s4_yellow_next", {28'b0, last_y}, 4'b0001);
    step_cyc(); step_cyc(); step_cyc(); step_cyc();
    chk("s4_emg_lane_green", {28'b0, last_g}, 4'b1000);
    tif.emg_req = 1'b0; tif.demand = 4'b1111;
    repeat (8) step_cyc();
    step_cyc();
    chk("s4_ptr_wrapped", {28'b0, last_g}, 4'b0001);

    // emergency on the active lane freezes green
    do_reset(); cur = "s5_freeze"; tif.demand = 4'b0010;
    step_cyc(); step_cyc();
    tif.emg_req = 1'b1; tif.emg_lane = 2'd1;
    ng = 0;
    repeat (10) begin step_cyc(); ng += int'(last_g == 4'b0010); end
    chk("s5_frozen_green", ng, 10);
    tif.emg_req = 1'b0;
    ng = 0;
    repeat (3) begin step_cyc(); ng += int'(last_g == 4'b0010); end
    chk("s5_remaining_green", ng, 3);
    step_cyc();
    chk("s5_then_yellow", {28'b0, last_y}, 4'b0010);

    // asynchronous reset in the middle of yellow
    do_reset(); cur = "s6_rst"; tif.demand = 4'b0100;
    repeat (6) step_cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("s6_green_off", {28'b0, tif.green}, 0);
    chk("s6_yellow_off", {28'b0, tif.yellow}, 0);
    chk("s6_phase_scan", {29'b0, tif.phase}, 0);
    m_reset(); tif.demand = 4'b1111;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step_cyc(); step_cyc();
    chk("s6_resume_ptr0", {28'b0, last_g}, 4'b0001);

    // randomized traffic against the model
    do_reset(); cur = "rand"; emg_on = 0;
    repeat (800) begin
      tif.tick    = ($urandom_range(0, 3) != 0);
      tif.demand  = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
      tif.congest = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) begin
        emg_on = !emg_on;
        tif.emg_lane = 2'($urandom_range(0, 3));
      end
      tif.emg_req = emg_on;
      step_cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/adaptive_tl_sequencer.md
# adaptive_tl_sequencer

Parametrised N-lane adaptive traffic-light sequencer. It is the next-generation replacement for the fixed 4-lane, Gray-coded lane FSM.
- Serves lanes round-robin and skips lanes with no demand.
- Times green, yellow and all-red phases with a tick-driven counter.
- Grants one congestion extension per green.
- Supports emergency pre-emption.
- Sits between the lane sensor conditioning logic and the lamp drivers.

## Interface
Parameters:
- NUM_LANES, 4, number of lanes (≥2)
- CNT_W, 8, phase timer width
- GREEN_MIN, 8, base green duration in ticks (1..2^CNT_W-1)
- GREEN_EXT, 8, extension duration in ticks (1..2^CNT_W-1)
- YELLOW_T, 3, yellow duration in ticks (1..2^CNT_W-1)
- ALLRED_T, 1, all-red clearance duration in ticks (1..2^CNT_W-1)
- LANE_W, max(1, clog2(NUM_LANES)), lane index width (derived; do not override)

Ports. One clock; reset is asynchronous and active-low.
- clk, in, 1, system clock
- rst_n, in, 1, asynchronous active-low reset
- tick, in, 1, timebase enable; timers advance only when high
- demand, in, NUM_LANES, per-lane start sensor (vehicle waiting)
- congest, in, NUM_LANES, per-lane congestion sensor
- emg_req, in, 1, emergency pre-emption request (level)
- emg_lane, in, LANE_W, lane requested by emergency; values ≥ NUM_LANES are ignored (treated as emg_req=0)
- green, out, NUM_LANES, one-hot green lamp (or zero)
- yellow, out, NUM_LANES, one-hot yellow lamp (or zero)
- active_lane, out, LANE_W, lane currently or last served
- phase, out, 3, state code: SCAN=0, GREEN=1, EXT=2, YELLOW=3, ALLRED=4
- served, out, 1, one-cycle pulse when ALLRED exits (lane service complete)

## Operation
- Lamps are Moore outputs decoded from the registered state:
  - green[active_lane]=1 in GREEN and EXT.
  - yellow[active_lane]=1 in YELLOW.
  - All lamps are zero in SCAN and ALLRED.
  - At most one lamp bit is ever set.
- Registers are a pointer ptr (LANE_W), a timer (CNT_W), and an ext_used flag.
- SCAN (evaluated every clk, independent of tick):
  - If a valid emg_req is present, select emg_lane.
  - Otherwise, select the first lane with demand=1 searching from ptr upward, wrapping modulo NUM_LANES.
  - If no lane is selected, stay in SCAN.
  - On selection: active_lane←lane, timer←GREEN_MIN, ext_used←0, next state GREEN.
- GREEN and EXT timing:
  - Each cycle with tick=1 decrements the timer.
  - The phase expires when tick=1 and timer==1.
- Expiry in GREEN:
  - If congest[active_lane]=1 and ext_used=0: go to EXT, timer←GREEN_EXT, ext_used←1.
  - Otherwise: go to YELLOW, timer←YELLOW_T.
- Expiry in EXT always goes to YELLOW; only one extension is granted per service.
- YELLOW on expiry goes to ALLRED, timer←ALLRED_T.
- ALLRED on expiry goes to SCAN, with ptr←(active_lane+1) mod NUM_LANES and served=1 for that cycle.
- Emergency, valid emg_req:
  - In GREEN or EXT with active_lane≠emg_lane: go to YELLOW immediately (timer←YELLOW_T). This takes priority over expiry or extension in the same cycle.
  - In GREEN or EXT with active_lane==emg_lane: the timer is frozen (no decrement, no expiry) while the request is held. Normal timing resumes once it drops.
  - YELLOW and ALLRED are never shortened or frozen by an emergency.
- Illegal state encodings go to SCAN with all lamps off.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert) sets:
  - phase=SCAN, ptr=0, active_lane=0, timer=0, ext_used=0
  - green=0, yellow=0, served=0
- Latency from demand to green: a demand visible in a SCAN cycle gives green on the next clk edge (1 cycle).
- With tick tied to 1, phase lengths are exactly GREEN_MIN, GREEN_EXT, YELLOW_T and ALLRED_T cycles. SCAN lasts at least 1 cycle between services.
- Sampling points:
  - congest is sampled only in the GREEN expiry cycle.
  - demand is sampled only in SCAN.
- Reset mid-phase drops lamps to all-off asynchronously.
- Simultaneous events:
  - Emergency preemption beats expiry.
  - Emergency selection in SCAN beats round-robin selection.

## Test plan
All scenarios use NUM_LANES=4, GREEN_MIN=4, GREEN_EXT=3, YELLOW_T=2, ALLRED_T=1, tick=1.
- Reset then demand=0001 -> 1 cycle SCAN, green=0001 for 4 cycles, yellow=0001 for 2, all-off for 1 with served pulse, 1 cycle SCAN, then lane 0 is served again (wrap).
- demand=1010, starting from ptr=0 -> lane 1 is served, then lane 3, then lane 1; lanes 0 and 2 are never lit.
- Lane 2 served with congest[2]=1 held -> green for 7 cycles (4+3), then yellow for 2. Holding congest does not grant a second extension.
- Lane 0 green in its 2nd cycle, emg_req=1, emg_lane=3 -> next cycle yellow=0001 for 2, all-red for 1, SCAN selects 3 despite demand[3]=0, then ptr=0.
- Lane 1 green, emg_req=1 with emg_lane=1 for 10 cycles -> green held for 10 cycles. After release, green for the remaining ticks, then yellow.
- Assert rst_n low mid-YELLOW -> green=yellow=0 and phase=0 immediately. After release, normal SCAN resumes from ptr=0.
